// File: rtl/shift_pkg.sv
// Shared types and defaults for the serial link transmit path.
// Holds the serializer state enum and the default width and bit order.
package shift_pkg;

  localparam int SHIFT_WIDTH_DEFAULT = 8;

  // 1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
  localparam bit SHIFT_MSB_FIRST_DEFAULT = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/shift_serializer.sv
// Parallel-in serial-out transmitter with a one-word hold buffer.
// Ports: clk, reset (async active-low), din/din_valid/din_ready in,
//        data/data_valid/frame_start/busy registered serial outputs.
module shift_serializer
  import shift_pkg::*;
#(
  parameter int WIDTH     = SHIFT_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = SHIFT_MSB_FIRST_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             data,
  output logic             data_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_t       state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic             accept;

  assign din_ready = !hold_full;
  assign accept    = din_valid && !hold_full;

  function automatic logic first_bit(
    input logic [WIDTH-1:0] w
  );
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // shreg keeps only the bits not yet on data
  function automatic logic [WIDTH-1:0] rest(
    input logic [WIDTH-1:0] w
  );
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      data        <= 1'b0;
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= SHIFT;
            bit_cnt     <= '0;
            shreg       <= rest(din);
            data        <= first_bit(din);
            data_valid  <= 1'b1;
            frame_start <= 1'b1;
            busy        <= 1'b1;
          end else begin
            data        <= 1'b0;
            data_valid  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
          end
        end
        SHIFT: begin
          if (bit_cnt == LAST) begin
            bit_cnt <= '0;
            // a held word wins; din_ready is low then
            if (hold_full) begin
              shreg       <= rest(hold);
              data        <= first_bit(hold);
              hold_full   <= 1'b0;
              frame_start <= 1'b1;
            end else if (accept) begin
              shreg       <= rest(din);
              data        <= first_bit(din);
              frame_start <= 1'b1;
            end else begin
              state       <= IDLE;
              data        <= 1'b0;
              data_valid  <= 1'b0;
              frame_start <= 1'b0;
              busy        <= 1'b0;
            end
          end else begin
            bit_cnt     <= bit_cnt + 1'b1;
            shreg       <= rest(shreg);
            data        <= first_bit(shreg);
            frame_start <= 1'b0;
            if (accept) begin
              hold      <= din;
              hold_full <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_serializer.sv
// Bench for shift_serializer: both bit orders against a frame model,
// plus a loopback receiver shifting data in on every clock.
module tb_shift_serializer;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic [W-1:0] din;
  logic         din_valid;

  logic rdy_m, d_m, dv_m, fs_m, bsy_m;
  logic rdy_l, d_l, dv_l, fs_l, bsy_l;

  shift_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (rdy_m),
    .data        (d_m),
    .data_valid  (dv_m),
    .frame_start (fs_m),
    .busy        (bsy_m)
  );

  shift_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (rdy_l),
    .data        (d_l),
    .data_valid  (dv_l),
    .frame_start (fs_l),
    .busy        (bsy_l)
  );

  logic [9:0] obs;
  assign obs = {rdy_m, dv_m, fs_m, bsy_m, d_m,
                rdy_l, dv_l, fs_l, bsy_l, d_l};

  int checks = 0;
  int errors = 0;

  // frame model: pos = index of bit on the wire, -1 when idle
  int           pos = -1;
  logic [W-1:0] cur = '0;
  logic [W-1:0] hq[$];
  logic [W-1:0] accq[$];
  logic [W-1:0] rxw[$];
  int           nb = 0;
  logic [W-1:0] sh = '0;
  logic [W-1:0] rx_m = '0;
  logic [W-1:0] rx_l = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // loopback receivers, shifting left every clock
  always @(posedge clk) begin
    rx_m <= {rx_m[W-2:0], d_m};
    rx_l <= {rx_l[W-2:0], d_l};
  end

  // regroup MSB-first payload bits into words
  initial forever begin
    @(negedge clk);
    if (!reset) nb = 0;
    else if (dv_m) begin
      sh = {sh[W-2:0], d_m};
      nb++;
      if (nb == W) begin
        rxw.push_back(sh);
        nb = 0;
      end
    end
  end

  function automatic logic [9:0] model_vec();
    logic r, v, f, bm, bl;
    r  = (hq.size() == 0);
    v  = (pos >= 0);
    f  = (pos == 0);
    bm = 1'b0;
    bl = 1'b0;
    if (v) begin
      bm = cur[W-1-pos];
      bl = cur[pos];
    end
    return {r, v, f, v, bm, r, v, f, v, bl};
  endfunction

  task automatic step(output bit acc);
    acc = reset && din_valid && (hq.size() == 0);
    @(posedge clk);
    if (!reset) begin
      pos = -1;
      hq.delete();
    end else if (pos < 0) begin
      if (acc) begin
        cur = din; pos = 0; accq.push_back(din);
      end
    end else if (pos == W-1) begin
      if (hq.size() != 0) begin
        cur = hq.pop_front(); pos = 0;
      end else if (acc) begin
        cur = din; pos = 0; accq.push_back(din);
      end else pos = -1;
    end else begin
      pos++;
      if (acc) begin
        hq.push_back(din); accq.push_back(din);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    bit acc;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (obs !== model_vec()) begin
      errors++;
      $display("FAIL reset_t0 got %b want %b", obs, model_vec());
    end
    for (int i = 0; i < 6; i++) begin
      din = W'($urandom);
      din_valid = 1'($urandom);
      step(acc);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL reset_hold%0d got %b want %b", i, obs, model_vec());
      end
    end
    reset = 1'b1;
    din_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(acc);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL reset_idle%0d got %b want %b", i, obs, model_vec());
      end
    end
  endtask

  task automatic test_single();
    bit acc;
    rxw.delete(); accq.delete();
    din = 8'hA5;
    din_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step(acc);
      din_valid = 1'b0;
      din = W'($urandom);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL single_c%0d got %b want %b", i, obs, model_vec());
      end
    end
    checks++;
    if (rxw.size() != 1 || rxw[0] !== 8'hA5) begin
      errors++;
      $display("FAIL single_word got n=%0d w=%h want n=1 w=a5",
               rxw.size(), rxw.size() ? rxw[0] : 8'h00);
    end
  endtask

  task automatic run_stream(input string nm,
                            input logic [W-1:0] w0,
                            input logic [W-1:0] w1,
                            input logic [W-1:0] w2,
                            input logic [W-1:0] w3,
                            input int nw);
    bit acc;
    logic [W-1:0] ws[4];
    int idx, first, last, nv;
    ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
    rxw.delete(); accq.delete();
    idx = 0; first = -1; last = -1; nv = 0;
    for (int c = 0; c < nw*W + 12; c++) begin
      din_valid = (idx < nw);
      din = (idx < nw) ? ws[idx] : W'($urandom);
      step(acc);
      if (acc) idx++;
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL %s_c%0d got %b want %b", nm, c, obs, model_vec());
      end
      if (dv_m) begin
        if (first < 0) first = c;
        last = c;
        nv++;
      end
    end
    din_valid = 1'b0;
    checks++;
    if (nv != nw*W || last - first + 1 != nw*W) begin
      errors++;
      $display("FAIL %s_contig got %0d bits span %0d want %0d",
               nm, nv, last - first + 1, nw*W);
    end
    checks++;
    if (rxw.size() != nw) begin
      errors++;
      $display("FAIL %s_count got %0d want %0d", nm, rxw.size(), nw);
    end else begin
      for (int k = 0; k < nw; k++) begin
        checks++;
        if (rxw[k] !== ws[k]) begin
          errors++;
          $display("FAIL %s_word%0d got %h want %h", nm, k, rxw[k], ws[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    run_stream("b2b", 8'hFF, 8'h00, 8'h3C, 8'h00, 3);
  endtask

  task automatic test_simultaneous();
    run_stream("simul", W'($urandom), W'($urandom),
               W'($urandom), W'($urandom), 4);
  endtask

  task automatic test_reset_mid();
    bit acc;
    rxw.delete(); accq.delete();
    din = 8'hC3; din_valid = 1'b1;
    step(acc);
    din = 8'h81;
    step(acc);
    din_valid = 1'b0;
    step(acc);
    step(acc);
    checks++;
    if (obs !== model_vec() || hq.size() != 1) begin
      errors++;
      $display("FAIL rmid_pre got %b want %b", obs, model_vec());
    end
    #2 reset = 1'b0;
    #1;
    pos = -1;
    hq.delete();
    checks++;
    if (obs !== model_vec()) begin
      errors++;
      $display("FAIL rmid_async got %b want %b", obs, model_vec());
    end
    step(acc);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(acc);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL rmid_after%0d got %b want %b", i, obs, model_vec());
      end
    end
    checks++;
    if (rxw.size() != 0) begin
      errors++;
      $display("FAIL rmid_residual got %0d words want 0", rxw.size());
    end
    accq.delete();
  endtask

  task automatic test_loopback();
    bit acc;
    logic [W-1:0] tw[2];
    logic [W-1:0] em[2];
    logic [W-1:0] el[2];
    tw[0] = 8'h5A; em[0] = 8'h5A; el[0] = 8'h5A;
    tw[1] = 8'h01; em[1] = 8'h01; el[1] = 8'h80;
    for (int k = 0; k < 2; k++) begin
      din = tw[k]; din_valid = 1'b1;
      step(acc);
      din_valid = 1'b0;
      for (int i = 0; i < W; i++) begin
        din = W'($urandom);
        step(acc);
        checks++;
        if (obs !== model_vec()) begin
          errors++;
          $display("FAIL loop%0d_c%0d got %b want %b",
                   k, i, obs, model_vec());
        end
      end
      checks++;
      if (rx_m !== em[k] || rx_l !== el[k]) begin
        errors++;
        $display("FAIL loop%0d_rx got msb=%h lsb=%h want msb=%h lsb=%h",
                 k, rx_m, rx_l, em[k], el[k]);
      end
    end
  endtask

  task automatic test_random();
    bit acc;
    rxw.delete(); accq.delete();
    for (int c = 0; c < 420; c++) begin
      din_valid = (c < 400) && ($urandom_range(0, 3) != 0);
      din = W'($urandom);
      step(acc);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL rand_c%0d got %b want %b", c, obs, model_vec());
      end
    end
    checks++;
    if (rxw.size() != accq.size()) begin
      errors++;
      $display("FAIL rand_count got %0d want %0d", rxw.size(), accq.size());
    end else begin
      for (int k = 0; k < accq.size(); k++) begin
        checks++;
        if (rxw[k] !== accq[k]) begin
          errors++;
          $display("FAIL rand_word%0d got %h want %h", k, rxw[k], accq[k]);
        end
      end
    end
  endtask

  initial begin
    din = '0;
    din_valid = 1'b0;
    reset = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    test_loopback();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
